hamming_similarity_enumerator: RTL

Inverse companion of the team's 4-bit Hamming-similarity comparator. The comparator maps a word pair to a count of matching bits; this block takes a reference word A and a target similarity K. It then streams out, one per handshake, every W-bit word B whose matching-bit count against A equals exactly K. It feeds comparator-checking benches and the lab's pattern generator.

---
 rtl/hamming_similarity_enumerator_if.sv | 28 ++
 rtl/hamming_similarity_enumerator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hamming_similarity_enumerator_if.sv
// Handshake bundle for the Hamming-similarity enumerator: request side
// (start/a/k), streamed result side (out_*) and run completion (done/count/err).
interface hamming_similarity_enumerator_if #(
    parameter int W  = 4,
    parameter int KW = $clog2(W + 1)
) ();
    logic              start;
    logic [W-1:0]      a;
    logic [KW-1:0]     k;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_word;
    logic [KW+W-1:0]   out_index;
    logic              done;
    logic [KW+W-1:0]   count;
    logic              err;

    modport master (
        output start, a, k, out_ready,
        input  busy, out_valid, out_word, out_index, done, count, err
    );

    modport slave (
        input  start, a, k, out_ready,
        output busy, out_valid, out_word, out_index, done, count, err
    );
endinterface

// File: rtl/hamming_similarity_enumerator.sv
// Streams every W-bit word B whose count of bits matching reference A equals K,
// scanning difference masks in ascending order and emitting B = A ^ mask.
module hamming_similarity_enumerator #(
    parameter int W  = 4,
    parameter int KW = $clog2(W + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    hamming_similarity_enumerator_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [KW-1:0]     k_q, k_d;
    // Extra top bit marks that the final mask has already been evaluated.
    logic [W:0]        mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_word_q, out_word_d;
    logic [KW+W-1:0]   out_index_q, out_index_d;
    logic              done_q, done_d;
    logic [KW+W-1:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [KW-1:0]     target_s;

    function automatic logic [KW-1:0] popcount(input logic [W-1:0] v);
        logic [KW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + KW'(v[i]);
        end
        return n;
    endfunction

    // Matching K bits means exactly W-K bits differ, i.e. the mask popcount.
    assign target_s = KW'(W) - k_q;

    // Next-state and output computation for the scan/hold handshake FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        k_d         = k_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d         = bus.a;
                    k_d         = bus.k;
                    mask_d      = '0;
                    out_index_d = '0;
                    busy_d      = 1'b1;
                    state_d     = (bus.k > KW'(W)) ? S_FIN : S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                mask_d = mask_q + (W + 1)'(1);
                if (popcount(mask_q[W-1:0]) == target_s) begin
                    out_word_d  = a_q ^ mask_q[W-1:0];
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (mask_q[W-1:0] == {W{1'b1}}) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_index_d = out_index_q + (KW + W)'(1);
                    state_d     = mask_q[W] ? S_FIN : S_SCAN;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                err_d   = (k_q > KW'(W));
                count_d = out_index_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            k_q         <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            k_q         <= k_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_index = out_index_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;

endmodule
